scope_trigger_capture: RTL and testbench
========================================

# scope_trigger_capture

Trigger-and-capture stage feeding the waveform drawer. It takes raw 14-bit ADC samples (already in the `clk` domain), decimates them and detects a level crossing (or times out). It then stores one screen line of 160 scaled Y coordinates and holds them stable while the drawer sweeps X and reads them back by address. It replaces free-running FIFO fill with a proper trigger so successive frames line up.

## Interface
- `N_SAMPLES`, 160: samples per frame, one per screen column.
- `Y_MAX`, 119: largest Y coordinate; top of plot is Y=0.
- `TIMEOUT`, 4096: kept samples without a trigger before auto-capture.
- `clk` in 1: system/pixel-logic clock; all logic on rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `adc_data` in 14: unsigned offset-binary sample.
- `adc_valid` in 1: one-cycle strobe, `adc_data` valid.
- `run` in 1: level; enables arming.
- `trig_level` in 14: trigger threshold.
- `trig_falling` in 1: 0 = rising-edge trigger, 1 = falling-edge trigger.
- `decim` in 8: keep 1 of every `decim`+1 valid samples.
- `rd_addr` in 8: drawer column (CounterX).
- `draw_done` in 1: one-cycle pulse, drawer finished the frame.
- `rd_data` out 8: Y coordinate for `rd_addr`, registered.
- `frame_ready` out 1: buffer holds a complete frame.
- `auto_trig` out 1: current frame was captured by timeout, not by trigger.

## Operation
- States: IDLE, PRIME, WAIT_TRIG, CAPTURE, READY.
- Transitions:
  - IDLE→PRIME when `run`=1.
  - PRIME→WAIT_TRIG on the first kept sample. That sample only loads `prev`.
  - WAIT_TRIG→CAPTURE on a trigger or timeout.
  - CAPTURE→READY after writing index `N_SAMPLES`-1.
  - READY→PRIME on `draw_done` if `run`=1, else READY→IDLE.
  - `run`=0 in PRIME or WAIT_TRIG → IDLE. CAPTURE always completes.
- Settings: `trig_level`, `trig_falling` and `decim` are latched on every entry to PRIME and are constant for that frame.
- Decimation counter:
  - Reloads to the latched `decim` on PRIME entry and after each kept sample.
  - Decrements on each `adc_valid`.
  - A sample is kept when `adc_valid`=1 and the counter=0.
  - `decim`=0 keeps every sample.
- Trigger condition on a kept sample `s`, compared against the previous kept sample `prev`:
  - Rising: `prev` < level and `s` ≥ level.
  - Falling: `prev` ≥ level and `s` < level.
  - `prev` updates on every kept sample in WAIT_TRIG.
- Trigger capture:
  - The triggering sample is written at index 0.
  - The next 159 kept samples are written at indices 1..159.
- Timeout:
  - Counts kept samples in WAIT_TRIG; cleared on PRIME entry.
  - On the `TIMEOUT`-th kept sample with no trigger, that sample is written at index 0 and `auto_trig` is set.
  - `auto_trig` is cleared on PRIME entry.
- Scaling: `y = Y_MAX - ((adc_data*120) >> 14)`.
  - The product is 21 bits, computed as `(x<<7)-(x<<3)`.
  - Result range is 0..119, stored in 8 bits.
  - `adc_data`=0 maps to 119; 16383 maps to 0.
- Writes are blocked outside WAIT_TRIG/CAPTURE, so the buffer is frozen in READY.
- Reads are accepted in any state. `rd_addr` ≥ `N_SAMPLES` returns 0.
- `draw_done` outside READY is ignored.
- `adc_valid` coincident with `draw_done` in READY is dropped.
- Reset values: state IDLE; `frame_ready`=0; `auto_trig`=0; `rd_data`=0; all counters 0. Buffer contents are not reset.

## Timing
- `rd_data` has 1-cycle latency: `rd_addr` sampled at edge k appears after edge k.
- A kept sample is written on the same edge it is accepted (its `adc_valid` edge).
- `frame_ready` rises on the edge after the index-159 write.
- `frame_ready` falls on the edge that samples `draw_done`.
- The trigger decision uses the current sample combinationally against the registered `prev`. Capture starts on the same edge, with no extra latency.
- Reset assertion mid-CAPTURE forces IDLE and drops `frame_ready` immediately (asynchronous). A partial frame is never flagged ready.

## Structure
- Shared package `vga_scope_pkg`:
  - State enum.
  - `N_SAMPLES`, `Y_MAX`, `TIMEOUT` defaults.
  - Y-scaling function, reused by the drawer test model.
- Sub-module `scope_line_ram`: 160×8 simple dual-port memory with one write port and one registered read port, no reset.
- Top level contains the FSM, decimator, trigger compare, timeout counter and write pointer.

## Test plan
- Trigger, rising edge, `decim`=0, level 8192: ramp 8000→8400 step 20 (kept) →
  - trigger on sample 8200;
  - `rd_addr` 0 reads `Y_MAX-((8200*120)>>14)`=59;
  - `frame_ready` rises 160 kept samples after arm;
  - `auto_trig`=0.
- Falling edge, `decim`=3: square wave 12000/4000 →
  - trigger only on a 12000→4000 transition;
  - exactly every 4th `adc_valid` is stored.
- Timeout: constant 5000 input, level 8192 →
  - capture starts on the 4096th kept sample;
  - `auto_trig`=1;
  - all 160 entries read 83.
- Frame hold and readback:
  - In READY, apply `adc_valid` for 1000 cycles → buffer unchanged.
  - `rd_addr`=200 → `rd_data`=0.
  - `draw_done` with `run`=1 → PRIME next cycle; `frame_ready`=0.
- Reset mid-CAPTURE at index 50 → `frame_ready`, `auto_trig`, `rd_data` all 0 asynchronously; state IDLE.
- Re-arm: `run`=0 during WAIT_TRIG → IDLE; no capture occurs even when a crossing arrives.

Source files
------------

// File: rtl/vga_scope_pkg.sv
// Shared definitions for the scope capture path and the drawer model:
// FSM states, frame geometry and the ADC-to-Y scaling.
package vga_scope_pkg;

  localparam int N_SAMPLES = 160;
  localparam int Y_MAX     = 119;
  localparam int TIMEOUT   = 4096;
  localparam int ADC_W     = 14;
  localparam int Y_W       = 8;
  localparam int ADDR_W    = 8;
  localparam int TCNT_W    = 13;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRIME,
    ST_WAIT_TRIG,
    ST_CAPTURE,
    ST_READY
  } scope_state_e;

  // x*120 as (x<<7)-(x<<3); the top 7 bits of the 21-bit product are 0..119
  function automatic logic [Y_W-1:0] scale_y(input logic [ADC_W-1:0] x);
    logic [20:0] prod;
    prod = ({7'd0, x} << 7) - ({7'd0, x} << 3);
    return 8'(Y_MAX) - {1'b0, prod[20:14]};
  endfunction

endpackage

// File: rtl/scope_line_ram.sv
// One screen line of Y coordinates: single write port, registered read port.
// Contents are deliberately left unreset.
module scope_line_ram #(
  parameter int DEPTH = 160,
  parameter int DW    = 8,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/scope_trigger_capture.sv
// Decimate ADC samples, wait for a level crossing (or time out), capture one
// frame of scaled Y values and hold it until the drawer reports completion.
module scope_trigger_capture
  import vga_scope_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [ADC_W-1:0]  adc_data,
  input  logic              adc_valid,
  input  logic              run,
  input  logic [ADC_W-1:0]  trig_level,
  input  logic              trig_falling,
  input  logic [7:0]        decim,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              draw_done,
  output logic [Y_W-1:0]    rd_data,
  output logic              frame_ready,
  output logic              auto_trig
);

  scope_state_e      state_q;
  logic [7:0]        dcnt_q;
  logic [TCNT_W-1:0] tcnt_q;
  logic [ADDR_W-1:0] wptr_q;
  logic              frame_ready_q;
  logic              auto_trig_q;
  logic              rd_ok_q;

  logic [ADC_W-1:0]  lvl_q;
  logic [ADC_W-1:0]  prev_q;
  logic              fall_q;
  logic [7:0]        decim_q;

  logic              active;
  logic              kept;
  logic              trig_hit;
  logic              tmo_hit;
  logic              prime_entry;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [Y_W-1:0]    wdata;
  logic [Y_W-1:0]    ram_rdata;

  always_comb begin
    active      = (state_q == ST_PRIME) || (state_q == ST_WAIT_TRIG) ||
                  (state_q == ST_CAPTURE);
    kept        = active && adc_valid && (dcnt_q == 8'd0);
    trig_hit    = fall_q ? ((prev_q >= lvl_q) && (adc_data <  lvl_q))
                         : ((prev_q <  lvl_q) && (adc_data >= lvl_q));
    tmo_hit     = (tcnt_q == TCNT_W'(TIMEOUT - 1));
    prime_entry = ((state_q == ST_IDLE) && run) ||
                  ((state_q == ST_READY) && draw_done && run);
    we          = 1'b0;
    waddr       = wptr_q;
    wdata       = scale_y(adc_data);
    if ((state_q == ST_WAIT_TRIG) && kept && run && (trig_hit || tmo_hit)) begin
      we    = 1'b1;
      waddr = '0;
    end else if ((state_q == ST_CAPTURE) && kept) begin
      we = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      dcnt_q        <= '0;
      tcnt_q        <= '0;
      wptr_q        <= '0;
      frame_ready_q <= 1'b0;
      auto_trig_q   <= 1'b0;
      rd_ok_q       <= 1'b0;
    end else begin
      rd_ok_q <= (rd_addr < ADDR_W'(N_SAMPLES));

      if (kept)                                 dcnt_q <= decim_q;
      else if (active && adc_valid)             dcnt_q <= dcnt_q - 8'd1;

      case (state_q)
        ST_IDLE: if (run) state_q <= ST_PRIME;
        ST_PRIME: begin
          if (!run)      state_q <= ST_IDLE;
          else if (kept) state_q <= ST_WAIT_TRIG;
        end
        ST_WAIT_TRIG: begin
          if (!run) begin
            state_q <= ST_IDLE;
          end else if (kept) begin
            if (trig_hit || tmo_hit) begin
              state_q     <= ST_CAPTURE;
              wptr_q      <= ADDR_W'(1);
              auto_trig_q <= !trig_hit;
            end else begin
              tcnt_q <= tcnt_q + 1'b1;
            end
          end
        end
        ST_CAPTURE: begin
          // run is ignored here so a started frame always completes
          if (kept) begin
            if (wptr_q == ADDR_W'(N_SAMPLES - 1)) state_q <= ST_READY;
            else                                  wptr_q  <= wptr_q + 1'b1;
          end
        end
        ST_READY: begin
          if (draw_done) begin
            frame_ready_q <= 1'b0;
            state_q       <= run ? ST_PRIME : ST_IDLE;
          end else begin
            frame_ready_q <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase

      if (prime_entry) begin
        dcnt_q      <= decim;
        tcnt_q      <= '0;
        wptr_q      <= '0;
        auto_trig_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (prime_entry) begin
      lvl_q   <= trig_level;
      fall_q  <= trig_falling;
      decim_q <= decim;
    end
    if (kept && ((state_q == ST_PRIME) || (state_q == ST_WAIT_TRIG)))
      prev_q <= adc_data;
  end

  scope_line_ram #(
    .DEPTH(N_SAMPLES),
    .DW   (Y_W),
    .AW   (ADDR_W)
  ) u_ram (
    .clk    (clk),
    .we_i   (we),
    .waddr_i(waddr),
    .wdata_i(wdata),
    .raddr_i(rd_addr),
    .rdata_o(ram_rdata)
  );

  // Out-of-range reads and reset force zero without a reset on the RAM itself
  assign rd_data     = rd_ok_q ? ram_rdata : '0;
  assign frame_ready = frame_ready_q;
  assign auto_trig   = auto_trig_q;

endmodule

// File: tb/tb_scope_trigger_capture.sv
// Directed bench for scope_trigger_capture: readback responses go through an
// expected-value queue checked by a separate monitor.
module tb_scope_trigger_capture;

  logic        clk = 1'b0;
  logic        reset;
  logic [13:0] adc_data;
  logic        adc_valid;
  logic        run;
  logic [13:0] trig_level;
  logic        trig_falling;
  logic [7:0]  decim;
  logic [7:0]  rd_addr;
  logic        draw_done;
  logic [7:0]  rd_data;
  logic        frame_ready;
  logic        auto_trig;

  int checks   = 0;
  int failures = 0;
  int exp_q[$];
  int exp_raw[160];
  logic rd_req  = 1'b0;
  logic rd_pend = 1'b0;

  always #5 clk = ~clk;

  scope_trigger_capture dut (
    .clk         (clk),
    .reset       (reset),
    .adc_data    (adc_data),
    .adc_valid   (adc_valid),
    .run         (run),
    .trig_level  (trig_level),
    .trig_falling(trig_falling),
    .decim       (decim),
    .rd_addr     (rd_addr),
    .draw_done   (draw_done),
    .rd_data     (rd_data),
    .frame_ready (frame_ready),
    .auto_trig   (auto_trig)
  );

  function automatic int yref(input int x);
    return 119 - (x * 120) / 16384;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input int req);
    checks++;
    if (act !== 32'(req)) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endtask

  always @(posedge clk) rd_pend <= rd_req;

  always @(negedge clk) begin
    if (rd_pend) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rd_sb: unexpected response %0d, required none", rd_data);
      end else begin
        chk("rd_data", 32'(rd_data), exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int d);
    adc_data  = 14'(d);
    adc_valid = 1'b1;
    tick();
    adc_valid = 1'b0;
  endtask

  task automatic rd(input int a, input int e);
    rd_addr = 8'(a);
    rd_req  = 1'b1;
    exp_q.push_back(e);
    tick();
    rd_req  = 1'b0;
  endtask

  task automatic rd_frame();
    for (int a = 0; a < 160; a++) rd(a, yref(exp_raw[a]));
    tick();
    tick();
  endtask

  task automatic wait_ready(input string nm, input int lim);
    int n;
    n = 0;
    while (!frame_ready && n < lim) begin
      tick();
      n++;
    end
    chk(nm, 32'(frame_ready), 1);
  endtask

  task automatic pulse_done();
    draw_done = 1'b1;
    tick();
    draw_done = 1'b0;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; adc_data = '0; adc_valid = 1'b0; run = 1'b0;
    trig_level = 14'd8192; trig_falling = 1'b0; decim = 8'd0;
    rd_addr = 8'd0; draw_done = 1'b0;
    #12;
    chk("rst_frame_ready", 32'(frame_ready), 0);
    chk("rst_auto_trig", 32'(auto_trig), 0);
    chk("rst_rd_data", 32'(rd_data), 0);
    tick();
    reset = 1'b1;
    tick();

    // Rising trigger, decim 0: ramp 8000..8400 step 20, then hold 8400
    run = 1'b1;
    tick();
    for (int v = 8000; v <= 8400; v += 20) send(v);
    for (int k = 0; k <= 10; k++) exp_raw[k] = 8200 + 20 * k;
    for (int k = 11; k < 160; k++) begin
      if (k == 159) chk("t1_not_early", 32'(frame_ready), 0);
      exp_raw[k] = 8400;
      send(8400);
    end
    chk("t1_ready_lag", 32'(frame_ready), 0);
    wait_ready("t1_frame_ready", 4);
    chk("t1_auto_trig", 32'(auto_trig), 0);
    rd(0, 59);
    rd_frame();
    rd(200, 0);
    tick();

    // Frame hold: samples arriving in READY must not touch the buffer
    for (int i = 0; i < 1000; i++) send((i * 37) % 16384);
    chk("hold_frame_ready", 32'(frame_ready), 1);
    rd(0, 59);
    rd(10, yref(8400));
    rd(159, yref(8400));
    tick();

    // Falling trigger, decim 3, square wave then a per-sample tag ramp
    trig_falling = 1'b1;
    decim = 8'd3;
    pulse_done();
    chk("t2_ready_drop", 32'(frame_ready), 0);
    for (int n = 1; n <= 16; n++) begin
      send((n <= 4 || n > 12) ? 4000 : 12000);
      if (n % 2 == 1) tick();
    end
    for (int n = 17; n <= 652; n++) begin
      send(100 + n);
      if (n % 2 == 1) tick();
    end
    exp_raw[0] = 4000;
    for (int k = 1; k < 160; k++) exp_raw[k] = 116 + 4 * k;
    wait_ready("t2_frame_ready", 4);
    chk("t2_auto_trig", 32'(auto_trig), 0);
    rd(0, 90);
    rd_frame();

    // Back to IDLE, then timeout capture with constant 5000
    trig_falling = 1'b0;
    decim = 8'd0;
    run = 1'b0;
    pulse_done();
    chk("t2_idle_ready", 32'(frame_ready), 0);
    run = 1'b1;
    tick();
    for (int i = 1; i <= 4256; i++) begin
      send(5000);
      if (i == 4096) chk("t3_no_early_tmo", 32'(auto_trig), 0);
      if (i == 4097) chk("t3_tmo_at_4096", 32'(auto_trig), 1);
      if (i == 4255) chk("t3_not_early", 32'(frame_ready), 0);
    end
    for (int k = 0; k < 160; k++) exp_raw[k] = 5000;
    wait_ready("t3_frame_ready", 4);
    chk("t3_auto_trig", 32'(auto_trig), 1);
    rd(0, 83);
    rd(159, 83);
    rd_frame();
    pulse_done();
    chk("t3_rearm_auto", 32'(auto_trig), 0);
    chk("t3_rearm_ready", 32'(frame_ready), 0);

    // Timeout capture again, reset at index 50
    for (int i = 1; i <= 1 + 4096 + 50; i++) send(5000);
    chk("t4_auto_before", 32'(auto_trig), 1);
    chk("t4_ready_before", 32'(frame_ready), 0);
    rd_addr = 8'd0;
    tick();
    tick();
    chk("t4_rd_before", 32'(rd_data), 83);
    #2 reset = 1'b0;
    #1;
    chk("t4_rst_ready", 32'(frame_ready), 0);
    chk("t4_rst_auto", 32'(auto_trig), 0);
    chk("t4_rst_rd", 32'(rd_data), 0);
    run = 1'b0;
    tick();
    reset = 1'b1;
    for (int i = 0; i < 10; i++) send(5000);
    chk("t4_no_partial", 32'(frame_ready), 0);

    // run dropped in WAIT_TRIG: a later crossing must not capture
    run = 1'b1;
    tick();
    send(8000);
    send(8100);
    run = 1'b0;
    tick();
    send(8300);
    for (int i = 0; i < 200; i++) send(8400);
    chk("t5_no_capture", 32'(frame_ready), 0);
    chk("t5_auto", 32'(auto_trig), 0);
    rd(0, 83);
    rd(50, 83);
    rd(51, 83);
    tick();
    tick();

    chk("sb_drain", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
